seq_scan_arbiter: RTL and testbench
===================================

# seq_scan_arbiter

Shared run-detector controller. Up to NREQ requesters each submit a WIDTH-bit word. The block arbitrates between them and shifts the granted word MSB-first through an internal three-state Mealy detector for runs of three or more consecutive 1s. It then returns the match count tagged with the requester id. It sits between the requester channels and the single serial detector resource, so one detector serves all channels.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, bits per word (≥3)
- CNT_W, 4, match-count width; must satisfy 2^CNT_W−1 ≥ WIDTH−2 or the count saturates
- IDW, 3, id width; ≥ clog2(NREQ)

- clk  in  1  clock, rising edge
- n_reset  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester request level
- data  in  NREQ*WIDTH  word of requester i at [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot, one-cycle pulse: word accepted
- busy  out  1  job in progress (SHIFT or DONE)
- done  out  1  one-cycle pulse: result valid
- done_id  out  IDW  requester of completed job; held until next done
- match_cnt  out  CNT_W  matches in completed job; held until next done
- hit_any  out  1  match_cnt != 0; held with match_cnt

## Operation
- Controller states: IDLE, SHIFT, DONE.
- IDLE: if any req, pick a winner, capture data[winner] into the shift register, load bit counter = WIDTH, clear detector to A and match accumulator to 0, go to SHIFT. Otherwise stay in IDLE.
- SHIFT: each cycle, feed shreg MSB to the detector, shift left, and decrement the counter. After the WIDTH-th bit, go to DONE.
- DONE: latch the accumulator into match_cnt and the winner into done_id, pulse done, go to IDLE.
- Detector, per bit b:
  - A: b=1 → B; b=0 → A.
  - B: b=1 → C; b=0 → A.
  - C: b=1 → C and match; b=0 → A.
  - Matching is overlapping: a run of k≥3 ones yields k−2 matches.
- Detector state never carries across jobs; it is forced to A at every capture.
- Accumulator is +1 per match and saturates at all-ones.
- Arbitration: round-robin. The pointer resets to 0. After a grant to i, the pointer becomes (i+1) mod NREQ. The search runs upward from the pointer with wrap.
- req is sampled only in IDLE. req changes during SHIFT/DONE are ignored.
- Requester must hold req and data stable until it sees its gnt bit. It may keep req high to queue another job.
- Reset (any time, including mid-job): state IDLE, pointer 0, detector A. gnt, busy, done, done_id, match_cnt, hit_any all 0. shreg and counter are 0.

## Timing
- Edge E0 (IDLE, req seen): capture happens. gnt[winner]=1 during the cycle after E0; busy=1 from then on.
- Bits are consumed on edges E1..E_WIDTH.
- done=1, with valid match_cnt/done_id/hit_any, during the cycle after edge E_WIDTH+1. busy is still 1 in that cycle.
- Next capture is at edge E_WIDTH+2 at the earliest. Throughput is one job per WIDTH+2 cycles.
- Request-to-done latency: WIDTH+2 edges from E0 to the done cycle.
- All outputs are registered. There are no combinational paths from req/data.

## Configuration
- SEQ_SCAN_FIXED_PRIO_EN defined: fixed priority, lowest index wins. The pointer logic is removed and a continuously requesting low index can starve higher indices.
- SEQ_SCAN_FIXED_PRIO_EN undefined (default): round-robin as specified above.
- All other behaviour is identical in both builds.

## Test plan
- Single job, NREQ=4, WIDTH=8: req=4'b0001, data0=8'b0111_1011 → gnt=4'b0001 pulse; done 9 cycles later; match_cnt=2, done_id=0, hit_any=1.
- Extremes: data=8'hFF → match_cnt=6; data=8'h00 → match_cnt=0, hit_any=0; data=8'b1101_1011 → match_cnt=0.
- Job isolation: job1 word ends in …11, then job2 word starts with 1,0… → job2 match_cnt=0 (no carry-over).
- Round-robin: req=4'b1111 held → grants in order 0,1,2,3,0, spaced 10 cycles apart. With SEQ_SCAN_FIXED_PRIO_EN defined, the same stimulus gives grants 0,0,0,0.
- Mid-job reset: assert n_reset during SHIFT bit 4 → all outputs 0 immediately. After release with req=4'b0110, the first grant is to index 1.
- Req churn: toggle req during SHIFT → no extra gnt; only one done per capture.

Source files
------------

// File: rtl/seq_scan_arbiter_if.sv
// Requester-side bundle for seq_scan_arbiter: request/data inputs and the
// grant/result outputs. The requester side holds the master modport and the
// arbiter holds the slave modport.
interface seq_scan_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int IDW   = 3
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [CNT_W-1:0]      match_cnt;
  logic                  hit_any;

  modport master (
    output req, data,
    input  gnt, busy, done, done_id, match_cnt, hit_any
  );

  modport slave (
    input  req, data,
    output gnt, busy, done, done_id, match_cnt, hit_any
  );
endinterface

// File: rtl/seq_scan_arbiter.sv
// seq_scan_arbiter: arbitrates NREQ requesters onto one serial run detector.
// The granted word is shifted MSB-first through a three-state Mealy detector
// that counts overlapping runs of three or more 1s; the saturating count is
// returned tagged with the requester id.
// Build option: SEQ_SCAN_FIXED_PRIO_EN selects fixed priority (lowest index
// wins) instead of the default round-robin arbitration.
module seq_scan_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int IDW   = 3
) (
  input  logic               clk,
  input  logic               n_reset,
  seq_scan_arbiter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {DET_A, DET_B, DET_C} det_t;

  state_t           state, state_n;
  det_t             det, det_n;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bitcnt;
  logic [CNT_W-1:0] acc;
  logic [IDW-1:0]   job_id;
  logic [IDW-1:0]   win;
  logic             any_req;
  logic             capture;
  logic             bit_in;
  logic             match;

`ifdef SEQ_SCAN_FIXED_PRIO_EN
  // Fixed priority: scan downward so the lowest requesting index is kept.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    win     = '0;
    any_req = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win     = IDW'(i);
        any_req = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] ptr;
  int             idx;

  // Round-robin: scan from ptr upward with wrap; the candidate nearest ptr
  // is assigned last and therefore wins.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    win     = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (bus.req[idx]) begin
        win     = IDW'(idx);
        any_req = 1'b1;
      end
    end
  end

  // Pointer moves just past the requester granted at each capture.
  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      ptr <= '0;
    end else if (capture) begin
      ptr <= (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
    end
  end
`endif

  // Controller state register.
  always_ff @(posedge clk or posedge n_reset) begin
    // NOTE: reset is asynchronous and active-high despite its name, so it
    // sits in the sensitivity list on its rising edge; all sequential state
    // uses non-blocking assignments so every register samples pre-edge
    // values regardless of block ordering.
    if (n_reset) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state logic; req is only looked at while IDLE.
  always_comb begin
    state_n = state;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          capture = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT:   if (bitcnt == CW'(1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Mealy run detector: a match is a 1 arriving while already in C.
  always_comb begin
    bit_in = shreg[WIDTH-1];
    det_n  = det;
    match  = 1'b0;
    case (det)
      DET_A: det_n = bit_in ? DET_B : DET_A;
      DET_B: det_n = bit_in ? DET_C : DET_A;
      DET_C: begin
        det_n = bit_in ? DET_C : DET_A;
        match = bit_in;
      end
      default: det_n = DET_A;
    endcase
  end

  // Job datapath: capture the winner's word, then shift and accumulate.
  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      // NOTE: the shift register and bit counter are cleared as well, so a
      // mid-job reset leaves no stale word or count behind.
      shreg  <= '0;
      bitcnt <= '0;
      det    <= DET_A;
      acc    <= '0;
      job_id <= '0;
    end else if (capture) begin
      shreg  <= bus.data[int'(win)*WIDTH +: WIDTH];
      bitcnt <= CW'(WIDTH);
      det    <= DET_A;
      acc    <= '0;
      job_id <= win;
    end else if (state == SHIFT) begin
      shreg  <= shreg << 1;
      bitcnt <= bitcnt - CW'(1);
      det    <= det_n;
      if (match && (acc != '1)) acc <= acc + CNT_W'(1);
    end
  end

  // Registered outputs: grant pulse, busy flag and the held job result.
  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      bus.gnt       <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.done_id   <= '0;
      bus.match_cnt <= '0;
      bus.hit_any   <= 1'b0;
    end else begin
      bus.gnt  <= capture ? (NREQ'(1) << win) : '0;
      bus.busy <= (state != IDLE) || capture;
      bus.done <= (state == DONE);
      if (state == DONE) begin
        bus.done_id   <= job_id;
        bus.match_cnt <= acc;
        bus.hit_any   <= (acc != '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Testbench for seq_scan_arbiter. A cycle driver plays the requesters and a
// reference model predicts grants and results; a separate monitor pops the
// predictions and compares them with what the DUT presents.
module tb_seq_scan_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int IDW   = 3;

  typedef struct {
    int id;
    int cnt;
    int cyc;
  } exp_t;

  logic clk;
  logic n_reset;
  int   cyc = 0;

  seq_scan_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W), .IDW(IDW)) bus ();

  seq_scan_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W), .IDW(IDW)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and counters.
  int   tests = 0;
  int   fails = 0;
  exp_t gnt_q[$];
  exp_t done_q[$];
  bit   busy_exp[int];
  bit   in_reset = 1'b1;
  int   last_id = 0;
  int   last_cnt = 0;

  // Requester / reference model state.
  logic [NREQ-1:0]  pend = '0;
  logic [WIDTH-1:0] pdata[NREQ];
  int               m_ptr = 0;
  int               cooldown = 0;
  bit               captured = 1'b0;
  int               cap_id = 0;
  int               cap_cyc = 0;
  int               n_caps = 0;
  int               keep_pct = 0;
  int               arrive_pct = 0;
  bit               churn_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Overlapping run count: each maximal run of k>=3 ones contributes k-2.
  function automatic int run_matches(input logic [WIDTH-1:0] w);
    int total = 0;
    int run = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w[i]) begin
        run++;
      end else begin
        if (run >= 3) total += run - 2;
        run = 0;
      end
    end
    if (run >= 3) total += run - 2;
    if (total > (1 << CNT_W) - 1) total = (1 << CNT_W) - 1;
    return total;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r);
`ifdef SEQ_SCAN_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int k = 0; k < NREQ; k++) if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
`endif
    return 0;
  endfunction

  // One clock of requester behaviour plus the model's view of the next edge.
  task automatic tick();
    int               w;
    int               upcoming;
    logic [NREQ-1:0]  drv;
    exp_t             e;
    @(negedge clk);
    if (captured) begin
      captured = 1'b0;
      if ($urandom_range(99) < keep_pct) pdata[cap_id] = WIDTH'($urandom);
      else                               pend[cap_id]  = 1'b0;
    end
    if (arrive_pct > 0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(99) < arrive_pct)) begin
          pend[i]  = 1'b1;
          pdata[i] = WIDTH'($urandom);
        end
      end
    end
    upcoming = cyc + 1;
    drv = pend;
    if (cooldown == 0 && pend != '0) begin
      w = pick(pend);
      e.id = w; e.cnt = 0; e.cyc = upcoming;
      gnt_q.push_back(e);
      e.cnt = run_matches(pdata[w]); e.cyc = upcoming + WIDTH + 1;
      done_q.push_back(e);
      for (int c = upcoming; c <= upcoming + WIDTH + 1; c++) busy_exp[c] = 1'b1;
      m_ptr    = (w + 1) % NREQ;
      cooldown = WIDTH + 1;
      captured = 1'b1;
      cap_id   = w;
      cap_cyc  = upcoming;
      n_caps++;
    end else if (cooldown > 0) begin
      cooldown--;
      if (churn_en) drv = NREQ'($urandom);
    end
    bus.req = drv;
    for (int i = 0; i < NREQ; i++)
      bus.data[i*WIDTH +: WIDTH] = (pend[i] || !churn_en) ? pdata[i] : WIDTH'($urandom);
  endtask

  task automatic run_until_idle(input int limit);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < limit; i++) begin
      idle = (pend == '0) && (cooldown == 0) && !captured &&
             (gnt_q.size() == 0) && (done_q.size() == 0);
      if (idle) break;
      tick();
    end
    check("idle_reached", 32'(idle), 32'd1);
  endtask

  task automatic one_job(input int id, input logic [WIDTH-1:0] word);
    pend[id]  = 1'b1;
    pdata[id] = word;
    run_until_idle(100);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},       32'(bus.gnt),       32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_done"},      32'(bus.done),      32'd0);
    check({tag, "_done_id"},   32'(bus.done_id),   32'd0);
    check({tag, "_match_cnt"}, 32'(bus.match_cnt), 32'd0);
    check({tag, "_hit_any"},   32'(bus.hit_any),   32'd0);
  endtask

  // Monitor: compares grant/done events and held outputs against the queues.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!in_reset) begin
      if (bus.gnt != '0 || (gnt_q.size() > 0 && gnt_q[0].cyc <= cyc)) begin
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", 32'(bus.gnt), 32'd0);
        end else begin
          mon_e = gnt_q.pop_front();
          check("gnt_onehot", 32'(bus.gnt), 32'(1 << mon_e.id));
          check("gnt_cycle",  32'(cyc),     32'(mon_e.cyc));
        end
      end
      if (bus.done || (done_q.size() > 0 && done_q[0].cyc <= cyc)) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 32'(bus.done), 32'd0);
        end else begin
          mon_e = done_q.pop_front();
          check("done_pulse",     32'(bus.done),      32'd1);
          check("done_cycle",     32'(cyc),           32'(mon_e.cyc));
          check("done_id",        32'(bus.done_id),   32'(mon_e.id));
          check("match_cnt",      32'(bus.match_cnt), 32'(mon_e.cnt));
          check("hit_any",        32'(bus.hit_any),   32'(mon_e.cnt != 0));
          last_id  = mon_e.id;
          last_cnt = mon_e.cnt;
        end
      end else begin
        check("held_result", {bus.done_id, bus.match_cnt, bus.hit_any},
              {IDW'(last_id), CNT_W'(last_cnt), last_cnt != 0});
      end
      check("busy", 32'(bus.busy), 32'(busy_exp.exists(cyc)));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREQ; i++) pdata[i] = '0;
    n_reset  = 1'b1;
    bus.req  = '0;
    bus.data = '0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    n_reset  = 1'b0;
    in_reset = 1'b0;

    // Directed single jobs on requester 0 and the data extremes.
    one_job(0, 8'b0111_1011);
    one_job(0, 8'hFF);
    one_job(0, 8'h00);
    one_job(0, 8'b1101_1011);
    one_job(2, 8'b1110_0111);

    // Job isolation: a trailing 11 must not seed the next job's detector.
    one_job(0, 8'b0000_0011);
    one_job(0, 8'b1011_0000);
    one_job(3, 8'b0000_0111);
    one_job(3, 8'b1100_0000);

    // All requesters held high: grant order follows the arbitration policy.
    keep_pct = 100;
    pend = '1;
    for (int i = 0; i < NREQ; i++) pdata[i] = WIDTH'($urandom);
    for (int i = 0; i < 200 && n_caps < 14; i++) tick();
    keep_pct = 0;
    run_until_idle(200);

    // Request churn while busy must not cause extra grants or results.
    churn_en = 1'b1;
    one_job(1, 8'b0011_1100);
    one_job(2, 8'hF0);
    churn_en = 1'b0;

    // Mid-job reset during the fourth shifted bit.
    pend[0]  = 1'b1;
    pdata[0] = 8'hFF;
    for (int i = 0; i < 50 && !captured; i++) tick();
    while (cyc < cap_cyc + 4) @(posedge clk);
    #2;
    in_reset = 1'b1;
    n_reset  = 1'b1;
    #1;
    check_all_zero("midreset");
    bus.req = '0;
    gnt_q.delete();
    done_q.delete();
    busy_exp.delete();
    pend     = '0;
    m_ptr    = 0;
    cooldown = 0;
    captured = 1'b0;
    last_id  = 0;
    last_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    n_reset  = 1'b0;
    in_reset = 1'b0;
    pend     = 4'b0110;
    pdata[1] = 8'b1111_0000;
    pdata[2] = 8'b0001_1111;
    run_until_idle(200);

    // Randomized traffic with arrivals, re-requests and churn.
    arrive_pct = 20;
    keep_pct   = 50;
    churn_en   = 1'b1;
    for (int i = 0; i < 1000; i++) tick();
    arrive_pct = 0;
    keep_pct   = 0;
    churn_en   = 1'b0;
    run_until_idle(300);

    check("queues_drained", 32'(gnt_q.size() + done_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
